// File: rtl/frame_buffer_pkg.sv
// Shared frame buffer geometry and write sequencer state encoding.
// Imported by the write sequencer and the address counter.
package frame_buffer_pkg;

  localparam int FB_DEPTH = 4800;
  localparam int FB_WIDTH = 12;
  localparam int FB_AW    = $clog2(FB_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    CLEAR
  } fws_state_t;

endpackage

// File: rtl/frame_addr_counter.sv
// Loadable/clearable frame address counter with terminal flag at DEPTH-1.
// Incrementing past the terminal value wraps to zero.
module frame_addr_counter
  import frame_buffer_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [AW-1:0] load_val_i,
  input  logic          inc_i,
  output logic [AW-1:0] cnt_o,
  output logic          term_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (clr_i)
      cnt_d = '0;
    else if (inc_i)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == LAST);

endmodule

// File: rtl/frame_write_sequencer.sv
// Arbitrates the frame buffer write port between sensor stream and clear.
// Optional stats outputs under FRAME_WRITE_SEQ_STATS_EN.
module frame_write_sequencer
  import frame_buffer_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int WIDTH = FB_WIDTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_req,
  input  logic [WIDTH-1:0] clear_value,
  input  logic             pix_valid,
  input  logic             pix_sof,
  input  logic [WIDTH-1:0] pix_data,
  output logic             pix_ready,
  output logic             mem_write_en,
  output logic [AW-1:0]    mem_write_addr,
  output logic [WIDTH-1:0] mem_data_in,
  output logic             busy,
  output logic             frame_done,
  output logic             clear_done,
`ifdef FRAME_WRITE_SEQ_STATS_EN
  output logic [15:0]      frame_count,
  output logic [7:0]       err_count,
`endif
  output logic             frame_err
);

  fws_state_t       state_q;
  logic             pend_q;
  logic [WIDTH-1:0] clr_val_q;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] data_q;
  logic             fdone_q, cdone_q, ferr_q;

  logic          xfer, abort;
  logic          cnt_clr, cnt_load, cnt_inc, cnt_term;
  logic [AW-1:0] cnt;

  // Reset gating keeps every output low while rst_n is asserted.
  assign pix_ready = rst_n &
    ((state_q == STREAM) | ((state_q == IDLE) & ~clear_req));
  assign xfer  = pix_valid & pix_ready;
  assign abort = pix_sof & (cnt != '0);

  always_comb begin
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state_q)
      IDLE:   cnt_load = ~clear_req & xfer & pix_sof;
      STREAM: begin
        cnt_load = xfer & abort;
        cnt_inc  = xfer & ~abort;
      end
      CLEAR:  cnt_inc = 1'b1;
      default: cnt_clr = 1'b1;
    endcase
  end

  frame_addr_counter #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (cnt_clr),
    .load_i    (cnt_load),
    .load_val_i(AW'(1)),
    .inc_i     (cnt_inc),
    .cnt_o     (cnt),
    .term_o    (cnt_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      clr_val_q <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      fdone_q   <= 1'b0;
      cdone_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      we_q    <= 1'b0;
      fdone_q <= 1'b0;
      cdone_q <= 1'b0;
      ferr_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (clear_req) begin
            state_q   <= CLEAR;
            clr_val_q <= clear_value;
          end else if (xfer && pix_sof) begin
            we_q    <= 1'b1;
            addr_q  <= '0;
            data_q  <= pix_data;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (clear_req) begin
            pend_q    <= 1'b1;
            clr_val_q <= clear_value;
          end
          if (xfer) begin
            we_q   <= 1'b1;
            data_q <= pix_data;
            if (abort) begin
              addr_q <= '0;
              ferr_q <= 1'b1;
            end else begin
              addr_q <= cnt;
              if (cnt_term) begin
                fdone_q <= 1'b1;
                state_q <= (pend_q | clear_req) ? CLEAR : IDLE;
              end
            end
          end
        end
        CLEAR: begin
          we_q   <= 1'b1;
          addr_q <= cnt;
          data_q <= clr_val_q;
          if (cnt_term) begin
            cdone_q <= 1'b1;
            pend_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_write_en   = we_q;
  assign mem_write_addr = addr_q;
  assign mem_data_in    = data_q;
  assign busy           = (state_q != IDLE);
  assign frame_done     = fdone_q;
  assign clear_done     = cdone_q;
  assign frame_err      = ferr_q;

`ifdef FRAME_WRITE_SEQ_STATS_EN
  logic [15:0] fcnt_q;
  logic [7:0]  ecnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      ecnt_q <= '0;
    end else begin
      if (fdone_q)
        fcnt_q <= fcnt_q + 16'd1;
      if (ferr_q && ecnt_q != 8'hFF)
        ecnt_q <= ecnt_q + 8'd1;
    end
  end

  assign frame_count = fcnt_q;
  assign err_count   = ecnt_q;
`endif

endmodule
